// File: rtl/pp_bank_ctrl_if.sv
// Bundle between the ping-pong bank controller and its upstream, downstream and bank ports.
interface pp_bank_ctrl_if #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned TOTAL_MODULES = 4
);
    localparam int unsigned SLICE_W = $clog2(TOTAL_MODULES);

    logic                  in_valid;
    logic                  in_ready;
    logic                  rd_ready;
    logic                  bank0_ena;
    logic                  bank0_wea;
    logic [ADDR_WIDTH-1:0] bank0_addra;
    logic                  bank1_ena;
    logic                  bank1_wea;
    logic [ADDR_WIDTH-1:0] bank1_addra;
    logic [SLICE_W-1:0]    slicing_idx;
    logic                  out_valid;
    logic                  out_bank;
    logic                  out_last;
    logic [1:0]            bank_full;

    modport master (
        input  in_valid, rd_ready,
        output in_ready,
        output bank0_ena, bank0_wea, bank0_addra,
        output bank1_ena, bank1_wea, bank1_addra,
        output slicing_idx, out_valid, out_bank, out_last, bank_full
    );

    modport slave (
        output in_valid, rd_ready,
        input  in_ready,
        input  bank0_ena, bank0_wea, bank0_addra,
        input  bank1_ena, bank1_wea, bank1_addra,
        input  slicing_idx, out_valid, out_bank, out_last, bank_full
    );
endinterface

// File: rtl/pp_bank_ctrl.sv
// Two-bank ping-pong controller: one bank fills from upstream while the other
// is drained TOTAL_MODULES times (one pass per slice) by the array feeder.
module pp_bank_ctrl #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned TOTAL_DEPTH   = 12,
    parameter int unsigned TOTAL_MODULES = 4,
    parameter int unsigned RD_LATENCY    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    pp_bank_ctrl_if.master  bus
);
    localparam int unsigned SLICE_W = $clog2(TOTAL_MODULES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(TOTAL_DEPTH - 1);
    localparam logic [SLICE_W-1:0]    SLICE_LAST = SLICE_W'(TOTAL_MODULES - 1);

    typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_DRAINING} bank_st_e;

    typedef struct packed {
        logic               valid;
        logic               bank;
        logic [SLICE_W-1:0] slice;
        logic               last;
    } rd_tag_t;

    bank_st_e              st_q [2];
    bank_st_e              st_d [2];
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [SLICE_W-1:0]    rd_slice_q, rd_slice_d;
    logic [1:0]            ena_q, ena_d;
    logic [1:0]            wea_q, wea_d;
    logic [ADDR_WIDTH-1:0] addr_q [2];
    logic [ADDR_WIDTH-1:0] addr_d [2];
    logic [1:0]            bank_full_q, bank_full_d;
    rd_tag_t               issue_tag;
    rd_tag_t               tag_q;
    rd_tag_t               pipe_q [RD_LATENCY];
    logic                  in_ready_c;
    logic                  rd_avail_c;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rd_end;

    assign in_ready_c = (st_q[wr_bank_q] == ST_EMPTY) || (st_q[wr_bank_q] == ST_FILLING);
    assign rd_avail_c = (st_q[rd_bank_q] == ST_FULL)  || (st_q[rd_bank_q] == ST_DRAINING);
    assign wr_fire    = bus.in_valid & in_ready_c;
    assign rd_fire    = bus.rd_ready & rd_avail_c;
    assign rd_end     = (rd_addr_q == ADDR_LAST) && (rd_slice_q == SLICE_LAST);

    // Next-state: bank roles, counters and the bank port values for the next cycle
    always_comb begin
        st_d        = st_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        rd_slice_d  = rd_slice_q;
        ena_d       = '0;
        wea_d       = '0;
        addr_d      = addr_q;
        issue_tag   = '0;
        bank_full_d = '0;

        if (wr_fire) begin
            ena_d[wr_bank_q]  = 1'b1;
            wea_d[wr_bank_q]  = 1'b1;
            addr_d[wr_bank_q] = wr_addr_q;
            if (wr_addr_q == ADDR_LAST) begin
                wr_addr_d        = '0;
                st_d[wr_bank_q]  = ST_FULL;
                wr_bank_d        = ~wr_bank_q;
            end else begin
                wr_addr_d        = wr_addr_q + ADDR_WIDTH'(1);
                st_d[wr_bank_q]  = ST_FILLING;
            end
        end

        if (rd_fire) begin
            ena_d[rd_bank_q]  = 1'b1;
            addr_d[rd_bank_q] = rd_addr_q;
            issue_tag         = '{valid: 1'b1, bank: rd_bank_q, slice: rd_slice_q, last: rd_end};
            if (rd_end) begin
                st_d[rd_bank_q] = ST_EMPTY;
                rd_bank_d       = ~rd_bank_q;
                rd_addr_d       = '0;
                rd_slice_d      = '0;
            end else begin
                st_d[rd_bank_q] = ST_DRAINING;
                if (rd_addr_q == ADDR_LAST) begin
                    rd_addr_d  = '0;
                    rd_slice_d = rd_slice_q + SLICE_W'(1);
                end else begin
                    rd_addr_d  = rd_addr_q + ADDR_WIDTH'(1);
                end
            end
        end

        for (int b = 0; b < 2; b++) begin
            bank_full_d[b] = (st_d[b] == ST_FULL) || (st_d[b] == ST_DRAINING);
        end
    end

    // State register; read tags trail the bank port by RD_LATENCY cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]     <= ST_EMPTY;
            st_q[1]     <= ST_EMPTY;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            rd_slice_q  <= '0;
            ena_q       <= '0;
            wea_q       <= '0;
            addr_q[0]   <= '0;
            addr_q[1]   <= '0;
            bank_full_q <= '0;
            tag_q       <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) pipe_q[i] <= '0;
        end else begin
            st_q        <= st_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            rd_slice_q  <= rd_slice_d;
            ena_q       <= ena_d;
            wea_q       <= wea_d;
            addr_q      <= addr_d;
            bank_full_q <= bank_full_d;
            tag_q       <= issue_tag;
            pipe_q[0]   <= tag_q;
            for (int i = 1; i < int'(RD_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.bank0_ena   = ena_q[0];
    assign bus.bank0_wea   = wea_q[0];
    assign bus.bank0_addra = addr_q[0];
    assign bus.bank1_ena   = ena_q[1];
    assign bus.bank1_wea   = wea_q[1];
    assign bus.bank1_addra = addr_q[1];
    assign bus.bank_full   = bank_full_q;
    assign bus.out_valid   = pipe_q[RD_LATENCY-1].valid;
    assign bus.out_bank    = pipe_q[RD_LATENCY-1].bank;
    assign bus.slicing_idx = pipe_q[RD_LATENCY-1].slice;
    assign bus.out_last    = pipe_q[RD_LATENCY-1].last;
endmodule
